// File: rtl/key_event_pkg.sv
// Shared definitions for the four-key press/release/auto-repeat event block.
// KEY_EVENT_REPEAT_EN selects the three-state auto-repeat channel; otherwise IDLE/HELD only.
package key_event_pkg;
   localparam int CNT_W            = 8;
   localparam int DEF_REPEAT_DELAY = 50;
   localparam int DEF_REPEAT_RATE  = 10;

`ifdef KEY_EVENT_REPEAT_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;
`else
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } state_t;
`endif
endpackage

// File: rtl/key_event_ch.sv
// Single key channel: registered press/release pulses, optional auto-repeat
// (enabled by KEY_EVENT_REPEAT_EN).
module key_event_ch
   import key_event_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_tick,
   input  logic i_key,
   output logic o_press,
   output logic o_rel
);

   state_t r_state, w_state_nxt;
   logic   r_prev, r_press, r_rel;
   logic   w_press_nxt, w_rel_nxt;
   logic   w_rise, w_fall;

   // prev is 0 in IDLE and 1 while held, so edges select the transitions
   assign w_rise = i_key & ~r_prev;
   assign w_fall = ~i_key & r_prev;

`ifdef KEY_EVENT_REPEAT_EN
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_cnt <= '0;
      else       r_cnt <= w_cnt_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_press_nxt = 1'b0;
      w_rel_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_state_nxt = ST_DELAY;
               w_cnt_nxt   = '0;
               w_press_nxt = 1'b1;
            end
         end
         ST_DELAY, ST_REPEAT: begin
            // release beats a coincident tick
            if (w_fall) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_rel_nxt   = 1'b1;
            end else if (i_tick) begin
               if (r_cnt == ((r_state == ST_DELAY) ? DELAY_LAST : RATE_LAST)) begin
                  w_state_nxt = ST_REPEAT;
                  w_cnt_nxt   = '0;
                  w_press_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end
`else
   logic w_unused;
   assign w_unused = &{1'b0, i_tick, REPEAT_DELAY[0], REPEAT_RATE[0], CNT_W[0]};

   always_comb begin
      w_state_nxt = r_state;
      w_press_nxt = 1'b0;
      w_rel_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_state_nxt = ST_HELD;
               w_press_nxt = 1'b1;
            end
         end
         ST_HELD: begin
            if (w_fall) begin
               w_state_nxt = ST_IDLE;
               w_rel_nxt   = 1'b1;
            end
         end
      endcase
   end
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_prev  <= 1'b0;
         r_press <= 1'b0;
         r_rel   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_prev  <= i_key;
         r_press <= w_press_nxt;
         r_rel   <= w_rel_nxt;
      end
   end

   assign o_press = r_press;
   assign o_rel   = r_rel;

endmodule

// File: rtl/key_event.sv
// Four independent key event channels plus a registered any-key level.
// Auto-repeat is built in only when KEY_EVENT_REPEAT_EN is defined.
module key_event
   import key_event_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
   input  logic clock,
   input  logic reset,
   input  logic clken100hz,
   input  logic key0in,
   input  logic key1in,
   input  logic key2in,
   input  logic key3in,
   output logic key0press,
   output logic key1press,
   output logic key2press,
   output logic key3press,
   output logic key0rel,
   output logic key1rel,
   output logic key2rel,
   output logic key3rel,
   output logic anykey
);

   logic [3:0] w_key, w_press, w_rel;
   logic       r_any;

   assign w_key = {key3in, key2in, key1in, key0in};

   for (genvar g = 0; g < 4; g++) begin : g_ch
      key_event_ch #(
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
      ) u_ch (
         .i_clk   (clock),
         .i_rst   (reset),
         .i_tick  (clken100hz),
         .i_key   (w_key[g]),
         .o_press (w_press[g]),
         .o_rel   (w_rel[g])
      );
   end

   always_ff @(posedge clock) begin
      if (reset) r_any <= 1'b0;
      else       r_any <= |w_key;
   end

   assign {key3press, key2press, key1press, key0press} = w_press;
   assign {key3rel, key2rel, key1rel, key0rel}         = w_rel;
   assign anykey = r_any;

endmodule

// File: tb/tb_key_event.sv
// Self-checking bench for key_event: scenario tasks plus random traffic,
// checked every cycle against a tick-counting reference model.
module tb_key_event;
   localparam int RD = 3;
   localparam int RR = 2;
`ifdef KEY_EVENT_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset, clken100hz;
   logic key0in, key1in, key2in, key3in;
   logic key0press, key1press, key2press, key3press;
   logic key0rel, key1rel, key2rel, key3rel;
   logic anykey;

   always #10 clock = ~clock;

   key_event #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
      .clock(clock), .reset(reset), .clken100hz(clken100hz),
      .key0in(key0in), .key1in(key1in), .key2in(key2in), .key3in(key3in),
      .key0press(key0press), .key1press(key1press), .key2press(key2press), .key3press(key3press),
      .key0rel(key0rel), .key1rel(key1rel), .key2rel(key2rel), .key3rel(key3rel),
      .anykey(anykey)
   );

   int n_chk = 0, n_fail = 0, cyc = 0;
   bit m_down[4];
   int m_ticks[4];
   int press_cnt[4], rel_cnt[4];
   logic [3:0] last_p, last_r;
   logic last_any;

   // Model: a held key presses on its rise, then on the RD-th held tick and
   // every RR ticks after that; ticks only count while the key stays held.
   task automatic step(input logic rst, input logic [3:0] k);
      logic tk;
      logic [3:0] ep, er;
      logic ea;
      @(negedge clock);
      tk = (cyc % 4 == 3);
      cyc++;
      reset = rst; clken100hz = tk;
      {key3in, key2in, key1in, key0in} = k;
      @(posedge clock); #1;
      ep = '0; er = '0;
      ea = !rst && (|k);
      for (int i = 0; i < 4; i++) begin
         if (rst) begin
            m_down[i] = 1'b0; m_ticks[i] = 0;
         end else if (!m_down[i]) begin
            if (k[i]) begin m_down[i] = 1'b1; m_ticks[i] = 0; ep[i] = 1'b1; end
         end else if (!k[i]) begin
            m_down[i] = 1'b0; er[i] = 1'b1;
         end else if (tk && REP) begin
            m_ticks[i]++;
            if (m_ticks[i] == RD || (m_ticks[i] > RD && (m_ticks[i] - RD) % RR == 0)) ep[i] = 1'b1;
         end
      end
      last_p   = {key3press, key2press, key1press, key0press};
      last_r   = {key3rel, key2rel, key1rel, key0rel};
      last_any = anykey;
      n_chk++;
      if (last_p !== ep) begin n_fail++; $display("FAIL press cyc=%0d got=%b exp=%b", cyc, last_p, ep); end
      n_chk++;
      if (last_r !== er) begin n_fail++; $display("FAIL rel cyc=%0d got=%b exp=%b", cyc, last_r, er); end
      n_chk++;
      if (last_any !== ea) begin n_fail++; $display("FAIL anykey cyc=%0d got=%b exp=%b", cyc, last_any, ea); end
      n_chk++;
      if ((last_p & last_r) !== 4'b0) begin n_fail++; $display("FAIL press_rel_excl cyc=%0d got=%b exp=0000", cyc, last_p & last_r); end
      for (int i = 0; i < 4; i++) begin
         if (last_p[i] === 1'b1) press_cnt[i]++;
         if (last_r[i] === 1'b1) rel_cnt[i]++;
      end
   endtask

   task automatic align();
      while (cyc % 4 != 0) step(1'b0, 4'b0);
   endtask

   task automatic clr_cnt();
      for (int i = 0; i < 4; i++) begin press_cnt[i] = 0; rel_cnt[i] = 0; end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 4'hF);
      for (int i = 0; i < 3; i++) step(1'b0, 4'h0);
   endtask

   task automatic test_single_press();
      align(); clr_cnt();
      for (int i = 0; i < 4; i++) step(1'b0, 4'b0001);
      for (int i = 0; i < 3; i++) step(1'b0, 4'b0000);
      n_chk++;
      if (press_cnt[0] != 1 || rel_cnt[0] != 1) begin
         n_fail++; $display("FAIL single_press got=%0d/%0d exp=1/1", press_cnt[0], rel_cnt[0]);
      end
   endtask

   task automatic test_repeat();
      int exp_p;
      align(); clr_cnt();
      for (int i = 0; i < 36; i++) step(1'b0, 4'b0010);
      step(1'b0, 4'b0000); step(1'b0, 4'b0000);
      exp_p = REP ? 5 : 1;
      n_chk++;
      if (press_cnt[1] != exp_p || rel_cnt[1] != 1) begin
         n_fail++; $display("FAIL repeat_count got=%0d/%0d exp=%0d/1", press_cnt[1], rel_cnt[1], exp_p);
      end
   endtask

   task automatic test_release_on_tick();
      align();
      for (int i = 0; i < 19; i++) step(1'b0, 4'b0100);
      step(1'b0, 4'b0000);
      n_chk++;
      if ({last_r[2], last_p[2]} !== 2'b10) begin
         n_fail++; $display("FAIL rel_on_tick got rel/press=%b%b exp=10", last_r[2], last_p[2]);
      end
   endtask

   task automatic test_simultaneous();
      step(1'b0, 4'h0); step(1'b0, 4'h0);
      step(1'b0, 4'hF);
      n_chk++;
      if (last_p !== 4'hF || last_any !== 1'b1) begin
         n_fail++; $display("FAIL simultaneous got press=%b any=%b exp=1111/1", last_p, last_any);
      end
      step(1'b0, 4'hF);
      step(1'b0, 4'h0);
      n_chk++;
      if (last_r !== 4'hF) begin n_fail++; $display("FAIL simul_rel got=%b exp=1111", last_r); end
   endtask

   task automatic test_reset_mid();
      align(); clr_cnt();
      for (int i = 0; i < 20; i++) step(1'b0, 4'b1000);
      step(1'b1, 4'b1000); step(1'b1, 4'b1000);
      n_chk++;
      if (rel_cnt[3] != 0 || last_p !== 4'b0) begin
         n_fail++; $display("FAIL reset_mid got rel_cnt=%0d press=%b exp=0/0000", rel_cnt[3], last_p);
      end
      step(1'b0, 4'b1000);
      n_chk++;
      if (last_p[3] !== 1'b1) begin n_fail++; $display("FAIL reset_repress got=%b exp=1", last_p[3]); end
      for (int i = 0; i < 16; i++) step(1'b0, 4'b1000);
      step(1'b0, 4'b0000);
   endtask

   task automatic test_back_to_back();
      step(1'b0, 4'b0001); step(1'b0, 4'b0001);
      step(1'b0, 4'b0000);
      n_chk++;
      if (last_r[0] !== 1'b1 || last_p[0] !== 1'b0) begin
         n_fail++; $display("FAIL b2b_rel got rel/press=%b%b exp=10", last_r[0], last_p[0]);
      end
      step(1'b0, 4'b0001);
      n_chk++;
      if (last_p[0] !== 1'b1 || last_r[0] !== 1'b0) begin
         n_fail++; $display("FAIL b2b_press got press/rel=%b%b exp=10", last_p[0], last_r[0]);
      end
      step(1'b0, 4'b0000);
   endtask

   task automatic test_random();
      logic [3:0] k = '0;
      for (int i = 0; i < 400; i++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(15) == 0) k[b] = ~k[b];
         step($urandom_range(99) == 0, k);
      end
   endtask

   initial begin
      reset = 1'b1; clken100hz = 1'b0;
      {key3in, key2in, key1in, key0in} = '0;
      test_reset();
      test_single_press();
      test_repeat();
      test_release_on_tick();
      test_simultaneous();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
